inst_fetch_queue: RTL

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/ifq_pkg.sv | 13 +
 rtl/ifq_fifo.sv | 89 ++++++++
 rtl/inst_fetch_queue.sv | 107 ++++++++++
 3 files changed

// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction fetch queue: instruction width,
// default queue depth and the control state encoding.
package ifq_pkg;

  localparam int INST_W    = 32;
  localparam int IFQ_DEPTH = 4;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } ifq_state_e;

endpackage

// File: rtl/ifq_fifo.sv
// Fetch queue storage: pc/instruction entries with filled bits, tail (allocate),
// fill (response write) and head (dequeue) pointers, all wrapping modulo DEPTH.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = IFQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              alloc_i,
  input  logic [WIDTH-1:0]  alloc_pc_i,
  input  logic              wr_i,
  input  logic [INST_W-1:0] wr_data_i,
  input  logic              deq_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [CNT_W-1:0]  pend_o,
  output logic              head_valid_o,
  output logic [WIDTH-1:0]  head_pc_o,
  output logic [INST_W-1:0] head_inst_o
);

  logic [WIDTH-1:0]  pc_q   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CNT_W-1:0]  count_q, count_d, pend_q, pend_d;

  // Responses arrive in order, so filled entries are always contiguous from head.
  always_comb begin
    filled_d = filled_q;
    head_d   = head_q;
    tail_d   = tail_q;
    fill_d   = fill_q;
    count_d  = count_q;
    pend_d   = pend_q;
    if (clear_i) begin
      filled_d = '0;
      head_d   = '0;
      tail_d   = '0;
      fill_d   = '0;
      count_d  = '0;
      pend_d   = '0;
    end else begin
      if (alloc_i) filled_d[tail_q] = 1'b0;
      if (wr_i)    filled_d[fill_q] = 1'b1;
      if (deq_i)   filled_d[head_q] = 1'b0;
      head_d  = head_q + PTR_W'(deq_i);
      tail_d  = tail_q + PTR_W'(alloc_i);
      fill_d  = fill_q + PTR_W'(wr_i);
      count_d = count_q + CNT_W'(alloc_i) - CNT_W'(deq_i);
      pend_d  = pend_q + CNT_W'(alloc_i) - CNT_W'(wr_i);
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      pend_q   <= '0;
    end else begin
      filled_q <= filled_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      fill_q   <= fill_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  // Payload storage is deliberately not reset; filled bits qualify it.
  always_ff @(posedge clk) begin
    if (alloc_i) pc_q[tail_q]   <= alloc_pc_i;
    if (wr_i)    inst_q[fill_q] <= wr_data_i;
  end

  assign count_o      = count_q;
  assign pend_o       = pend_q;
  assign head_valid_o = filled_q[head_q];
  assign head_pc_o    = pc_q[head_q];
  assign head_inst_o  = inst_q[head_q];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue control: request issue, flush handling and response
// draining. Define IFQ_PERF_EN to add the stall/flush performance counters.
//
// state | meaning
// RUN   | normal operation, requests issued while the queue has room
// DRAIN | queue empty after a flush, discarding drop_q stale responses
module inst_fetch_queue
  import ifq_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  fetch_pc,
  input  logic              flush,
  output logic              pc_stall,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [WIDTH-1:0]  imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [WIDTH-1:0]  id_pc,
  output logic [INST_W-1:0] id_inst
`ifdef IFQ_PERF_EN
  ,
  output logic [63:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  ifq_state_e       state_q;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] fifo_count, fifo_pend, drop_flush;
  logic             fire, resp_accept, deq, head_valid;

  // Outputs are gated by rst so the PC stage sees a stall throughout reset.
  assign imem_req_addr  = fetch_pc;
  assign imem_req_valid = rst & (state_q == RUN) & (fifo_count < CNT_W'(DEPTH)) & ~flush;
  assign fire           = imem_req_valid & imem_req_ready;
  assign pc_stall       = ~rst | (~fire & ~flush);
  assign resp_accept    = imem_resp_valid & (state_q == RUN) & ~flush & (fifo_pend != '0);
  assign id_valid       = head_valid;
  assign deq            = head_valid & id_ready & ~flush;

  // A response landing in the flush cycle is already dropped, so it is not counted.
  assign drop_flush = fifo_pend - CNT_W'(imem_resp_valid && (fifo_pend != '0));

  ifq_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_i       (rst),
    .clear_i     (flush),
    .alloc_i     (fire),
    .alloc_pc_i  (fetch_pc),
    .wr_i        (resp_accept),
    .wr_data_i   (imem_resp_data),
    .deq_i       (deq),
    .count_o     (fifo_count),
    .pend_o      (fifo_pend),
    .head_valid_o(head_valid),
    .head_pc_o   (id_pc),
    .head_inst_o (id_inst)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      drop_q  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (flush) begin
            drop_q  <= drop_flush;
            state_q <= (drop_flush != '0) ? DRAIN : RUN;
          end
        end
        DRAIN: begin
          if (imem_resp_valid) begin
            drop_q <= drop_q - CNT_W'(1);
            if (drop_q == CNT_W'(1)) state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!rst)
    imem_resp_valid |-> ((state_q == DRAIN) || (fifo_pend != '0)));

`ifdef IFQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pc_stall && !imem_req_valid) perf_stall_cnt <= perf_stall_cnt + 64'd1;
      if (flush)                       perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
